// File: rtl/light_sequencer.sv
// Phase controller for a two-road intersection: drives an external BCD down-counter,
// steps the light phases on counter zero, serves pedestrian requests and overrides on emergency.
module light_sequencer #(
    parameter logic [7:0] T_GREEN  = 8'h25,
    parameter logic [7:0] T_WALK   = 8'h35,
    parameter logic [7:0] T_YELLOW = 8'h03,
    parameter logic [7:0] T_ALLRED = 8'h02
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       done,
    input  logic       ped_req,
    input  logic       emerg,
    output logic       load,
    output logic [7:0] data,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ALLR2 = 3'd0,
        NS_G  = 3'd1,
        NS_Y  = 3'd2,
        ALLR1 = 3'd3,
        EW_G  = 3'd4,
        EW_Y  = 3'd5,
        EMERG = 3'd6
    } state_t;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    // Held as a plain vector so the unused code 7 is representable and recoverable.
    logic [2:0] state_reg, state_next;
    state_t     target;
    logic       step;
    logic       advance;
    logic       enter_ew_g;
    logic       load_reg, load_next;
    logic [7:0] data_reg, data_next;
    logic [2:0] ns_reg, ns_next;
    logic [2:0] ew_reg, ew_next;
    logic       walk_reg, walk_next;
    logic       ped_pend_reg, ped_pend_next;

    function automatic logic [7:0] duration_of(input state_t s, input logic serve_walk);
        logic [7:0] d;
        d = 8'h00;
        case (s)
            NS_G:        d = T_GREEN;
            EW_G:        d = serve_walk ? T_WALK : T_GREEN;
            NS_Y, EW_Y:  d = T_YELLOW;
            ALLR1,ALLR2: d = T_ALLRED;
            default:     d = 8'h00;
        endcase
        return d;
    endfunction

    always_comb begin
        // done is stale while a load is still waiting for its tick
        advance = tick && done && !load_reg;
        step    = 1'b0;
        target  = ALLR2;
        if (emerg) begin
            target = EMERG;
            step   = (state_reg != EMERG);
        end else begin
            case (state_reg)
                ALLR2:   begin target = NS_G;  step = advance; end
                NS_G:    begin target = NS_Y;  step = advance; end
                NS_Y:    begin target = ALLR1; step = advance; end
                ALLR1:   begin target = EW_G;  step = advance; end
                EW_G:    begin target = EW_Y;  step = advance; end
                EW_Y:    begin target = ALLR2; step = advance; end
                default: begin target = ALLR2; step = 1'b1;    end
            endcase
        end

        state_next    = step ? target : state_reg;
        enter_ew_g    = step && (target == EW_G);
        load_next     = step ? 1'b1 : (tick ? 1'b0 : load_reg);
        data_next     = step ? duration_of(target, ped_pend_reg) : data_reg;
        walk_next     = step ? (enter_ew_g && ped_pend_reg) : walk_reg;
        ped_pend_next = ped_req | (ped_pend_reg & ~enter_ew_g);
    end

    always_comb begin
        ns_next = LAMP_R;
        ew_next = LAMP_R;
        case (state_next)
            NS_G:    ns_next = LAMP_G;
            NS_Y:    ns_next = LAMP_Y;
            EW_G:    ew_next = LAMP_G;
            EW_Y:    ew_next = LAMP_Y;
            default: begin
                ns_next = LAMP_R;
                ew_next = LAMP_R;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ALLR2;
            load_reg     <= 1'b1;
            data_reg     <= T_ALLRED;
            ns_reg       <= LAMP_R;
            ew_reg       <= LAMP_R;
            walk_reg     <= 1'b0;
            ped_pend_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            load_reg     <= load_next;
            data_reg     <= data_next;
            ns_reg       <= ns_next;
            ew_reg       <= ew_next;
            walk_reg     <= walk_next;
            ped_pend_reg <= ped_pend_next;
        end
    end

    assign state    = state_reg;
    assign load     = load_reg;
    assign data     = data_reg;
    assign ns_light = ns_reg;
    assign ew_light = ew_reg;
    assign walk     = walk_reg;

endmodule

// File: tb/tb_light_sequencer.sv
// Bench for light_sequencer: BCD down-counter model plus a transition scoreboard
// fed by directed scenarios and drained by an independent monitor.
module tb_light_sequencer;

    localparam logic [7:0] TG = 8'h05;
    localparam logic [7:0] TW = 8'h09;
    localparam logic [7:0] TY = 8'h02;
    localparam logic [7:0] TA = 8'h01;

    localparam logic [2:0] S_ALLR2 = 3'd0;
    localparam logic [2:0] S_NS_G  = 3'd1;
    localparam logic [2:0] S_NS_Y  = 3'd2;
    localparam logic [2:0] S_ALLR1 = 3'd3;
    localparam logic [2:0] S_EW_G  = 3'd4;
    localparam logic [2:0] S_EW_Y  = 3'd5;
    localparam logic [2:0] S_EMERG = 3'd6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       done;
    logic       ped_req = 1'b0;
    logic       emerg = 1'b0;
    logic       load;
    logic [7:0] data;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic [2:0] state;

    logic [7:0] cnt;
    bit         tick_en = 1'b0;
    bit         mon_en = 1'b1;
    int         tick_phase = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    typedef struct {
        logic [2:0] st;
        logic [2:0] ns;
        logic [2:0] ew;
        logic       wk;
        logic [7:0] dat;
        int         dur;
    } exp_t;

    exp_t sb_q[$];

    light_sequencer #(
        .T_GREEN (TG),
        .T_WALK  (TW),
        .T_YELLOW(TY),
        .T_ALLRED(TA)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .done    (done),
        .ped_req (ped_req),
        .emerg   (emerg),
        .load    (load),
        .data    (data),
        .ns_light(ns_light),
        .ew_light(ew_light),
        .walk    (walk),
        .state   (state)
    );

    initial forever #5 clk = ~clk;

    // One-clk tick every 4 clocks, changed on the falling edge
    initial forever begin
        @(negedge clk);
        tick_phase = (tick_phase + 1) % 4;
        tick = tick_en && (tick_phase == 3);
    end

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'h0) return {v[7:4] - 4'd1, 4'h9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= 8'h00;
        else if (tick) begin
            if (load) cnt <= data;
            else if (cnt != 8'h00) cnt <= bcd_dec(cnt);
        end
    end
    assign done = (cnt == 8'h00);

    // {ns, ew} lamp pattern for each state code
    function automatic logic [5:0] lamps(input logic [2:0] s);
        case (s)
            3'd1:    return 6'b001_100;
            3'd2:    return 6'b010_100;
            3'd4:    return 6'b100_001;
            3'd5:    return 6'b100_010;
            default: return 6'b100_100;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // dur = tick count of the phase being left; -1 means not checked
    task automatic expect_tr(input logic [2:0] s, input logic w, input logic [7:0] d, input int dur);
        exp_t       e;
        logic [5:0] l;
        l     = lamps(s);
        e.st  = s;
        e.ns  = l[5:3];
        e.ew  = l[2:0];
        e.wk  = w;
        e.dat = d;
        e.dur = dur;
        sb_q.push_back(e);
    endtask

    task automatic wait_empty(input string tag);
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: %0d expected transitions pending, required 0", tag, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic wait_ticks(input int n);
        int seen;
        int guard;
        seen  = 0;
        guard = 0;
        while (seen < n && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
            if (tick) seen++;
        end
        if (seen < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tick_wait: saw %0d ticks, required %0d", seen, n);
        end
    endtask

    // Monitor: every state change pops one expected transition
    initial begin : monitor
        logic [2:0] prev;
        int         ticks;
        int         n_tr;
        exp_t       e;
        prev  = S_ALLR2;
        ticks = -1;
        n_tr  = 0;
        forever begin
            @(posedge clk); #1;
            if (rst || !mon_en) begin
                prev  = state;
                ticks = -1;
            end else begin
                if (tick) ticks++;
                if (state != prev) begin
                    n_tr++;
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_transition: state %0d -> %0d, required no transition", prev, state);
                    end else begin
                        e = sb_q.pop_front();
                        $display("trans %0d @%0t: %0d -> %0d ns=%b ew=%b walk=%b load=%b data=%h after %0d ticks",
                                 n_tr, $time, prev, state, ns_light, ew_light, walk, load, data, ticks);
                        chk($sformatf("tr%0d.state", n_tr), state, e.st);
                        chk($sformatf("tr%0d.ns_light", n_tr), ns_light, e.ns);
                        chk($sformatf("tr%0d.ew_light", n_tr), ew_light, e.ew);
                        chk($sformatf("tr%0d.walk", n_tr), walk, e.wk);
                        chk($sformatf("tr%0d.load", n_tr), load, 1'b1);
                        chk($sformatf("tr%0d.data", n_tr), data, e.dat);
                        if (e.dur >= 0) chk($sformatf("tr%0d.phase_ticks", n_tr), ticks, e.dur);
                    end
                    // A transition on a tick edge starts the phase's tick count; otherwise
                    // the first tick (which performs the load) plays that role.
                    ticks = tick ? 0 : -1;
                    prev  = state;
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int guard;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("reset.state", state, S_ALLR2);
        chk("reset.ns_light", ns_light, 3'b100);
        chk("reset.ew_light", ew_light, 3'b100);
        chk("reset.walk", walk, 1'b0);
        chk("reset.load", load, 1'b1);
        chk("reset.data", data, TA);

        // Free-running sequence, no requests
        expect_tr(S_NS_G,  1'b0, TG, 2);
        expect_tr(S_NS_Y,  1'b0, TY, 7);
        expect_tr(S_ALLR1, 1'b0, TA, 4);
        expect_tr(S_EW_G,  1'b0, TG, 3);
        expect_tr(S_EW_Y,  1'b0, TY, 7);
        expect_tr(S_ALLR2, 1'b0, TA, 4);
        expect_tr(S_NS_G,  1'b0, TG, 3);
        @(negedge clk);
        rst     = 1'b0;
        tick_en = 1'b1;
        wait_empty("free_run");

        // Pedestrian pulse during NS_G: served once, then cleared
        expect_tr(S_NS_Y,  1'b0, TY, 7);
        expect_tr(S_ALLR1, 1'b0, TA, 4);
        expect_tr(S_EW_G,  1'b1, TW, 3);
        expect_tr(S_EW_Y,  1'b0, TY, 11);
        expect_tr(S_ALLR2, 1'b0, TA, 4);
        expect_tr(S_NS_G,  1'b0, TG, 3);
        expect_tr(S_NS_Y,  1'b0, TY, 7);
        expect_tr(S_ALLR1, 1'b0, TA, 4);
        expect_tr(S_EW_G,  1'b0, TG, 3);
        expect_tr(S_EW_Y,  1'b0, TY, 7);
        @(negedge clk) ped_req = 1'b1;
        @(negedge clk) ped_req = 1'b0;
        wait_empty("ped_pulse");

        // Request held across EW_G entry: stays pending for the following EW_G
        expect_tr(S_ALLR2, 1'b0, TA, 4);
        expect_tr(S_NS_G,  1'b0, TG, 3);
        expect_tr(S_NS_Y,  1'b0, TY, 7);
        expect_tr(S_ALLR1, 1'b0, TA, 4);
        expect_tr(S_EW_G,  1'b1, TW, 3);
        @(negedge clk) ped_req = 1'b1;
        wait_empty("ped_held_a");
        @(negedge clk) ped_req = 1'b0;
        expect_tr(S_EW_Y,  1'b0, TY, 11);
        expect_tr(S_ALLR2, 1'b0, TA, 4);
        expect_tr(S_NS_G,  1'b0, TG, 3);
        expect_tr(S_NS_Y,  1'b0, TY, 7);
        expect_tr(S_ALLR1, 1'b0, TA, 4);
        expect_tr(S_EW_G,  1'b1, TW, 3);
        expect_tr(S_EW_Y,  1'b0, TY, 11);
        wait_empty("ped_held_b");

        // Emergency mid-EW_G, between ticks
        expect_tr(S_ALLR2, 1'b0, TA, 4);
        expect_tr(S_NS_G,  1'b0, TG, 3);
        expect_tr(S_NS_Y,  1'b0, TY, 7);
        expect_tr(S_ALLR1, 1'b0, TA, 4);
        expect_tr(S_EW_G,  1'b0, TG, 3);
        wait_empty("to_ew_g");
        wait_ticks(2);
        expect_tr(S_EMERG, 1'b0, 8'h00, -1);
        emerg = 1'b1;
        @(posedge clk); #1;
        chk("emerg_entry.state", state, S_EMERG);
        wait_ticks(2);
        chk("emerg_hold.state", state, S_EMERG);
        chk("emerg_hold.load", load, 1'b0);
        expect_tr(S_ALLR2, 1'b0, TA, -1);
        expect_tr(S_NS_G,  1'b0, TG, 2);
        expect_tr(S_NS_Y,  1'b0, TY, 7);
        expect_tr(S_ALLR1, 1'b0, TA, 4);
        expect_tr(S_EW_G,  1'b0, TG, 3);
        emerg = 1'b0;
        @(posedge clk); #1;
        chk("emerg_exit.state", state, S_ALLR2);
        wait_empty("emerg_resume");

        // Emergency on the very cycle that would advance EW_G
        expect_tr(S_EMERG, 1'b0, 8'h00, -1);
        guard = 0;
        while (!(state == S_EW_G && cnt == 8'h00 && !load && tick_phase == 2) && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("advance_ready", (state == S_EW_G && done && !load) ? 1 : 0, 1);
        emerg = 1'b1;
        @(posedge clk); #1;
        chk("emerg_vs_advance.state", state, S_EMERG);
        wait_ticks(2);
        expect_tr(S_ALLR2, 1'b0, TA, -1);
        expect_tr(S_NS_G,  1'b0, TG, 2);
        expect_tr(S_NS_Y,  1'b0, TY, 7);
        emerg = 1'b0;
        wait_empty("emerg2_resume");

        // Reset pulse mid-NS_Y with no tick
        wait_ticks(1);
        tick_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst.state", state, S_NS_Y);
        chk("pre_rst.load", load, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst.state", state, S_ALLR2);
        chk("mid_rst.ns_light", ns_light, 3'b100);
        chk("mid_rst.ew_light", ew_light, 3'b100);
        chk("mid_rst.walk", walk, 1'b0);
        chk("mid_rst.load", load, 1'b1);
        chk("mid_rst.data", data, TA);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Illegal state code recovers to ALLR2 on the next clock
        tick_en = 1'b1;
        wait_ticks(1);
        tick_en = 1'b0;
        chk("pre_force.load", load, 1'b0);
        mon_en = 1'b0;
        force dut.state_reg = 3'd7;
        @(negedge clk);
        release dut.state_reg;
        @(posedge clk); #1;
        chk("illegal.state", state, S_ALLR2);
        chk("illegal.load", load, 1'b1);
        chk("illegal.data", data, TA);
        chk("illegal.ns_light", ns_light, 3'b100);

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL leftover_expected: %0d pending, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
